ifetch_resp: RTL

- Responder end of the PC fetch interface: samples the PC-register address, fetches the instruction word over a ready-handshaked instruction-memory port, and returns instruction, address and valid to the decode stage.
- Drives the hold request back to the PC register to stall it while a fetch is in flight.
- Squashes in-flight fetches on jump and reports misaligned and timed-out fetches.

---
 rtl/ifetch_resp_pkg.sv | 17 +
 rtl/ifetch_resp_timeout_cnt.sv | 29 ++
 rtl/ifetch_resp.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ifetch_resp_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch responder.
package ifetch_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic HOLD_ENABLE  = 1'b1;
    localparam logic HOLD_DISABLE = 1'b0;
    localparam logic JUMP_ENABLE  = 1'b1;

    localparam int          TIMEOUT_DEFAULT  = 16;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/ifetch_resp_timeout_cnt.sv
// Saturating wait-cycle counter; o_terminal flags the last permitted wait cycle.
module ifetch_resp_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_terminal
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/ifetch_resp.sv
// Fetch responder: takes the PC, runs one memory request at a time and hands
// the instruction to decode, stalling the PC while a fetch is outstanding.
module ifetch_resp
    import ifetch_resp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_flag_i,
    output logic              hold_flag_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              fetch_err_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_addr;
    logic              r_inst_valid;
    logic              r_fetch_err;

    logic w_jump;
    logic w_misaligned;
    logic w_terminal;
    logic w_start;
    logic w_mis_err;
    logic w_done;
    logic w_abort;
    logic w_req_end;

    assign w_jump       = (jump_flag_i == JUMP_ENABLE);
    assign w_misaligned = (pc_i[1:0] != 2'b00);

    ifetch_resp_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start),
        .i_en       (r_state != ST_IDLE),
        .o_terminal (w_terminal)
    );

    // Event decode; a jump always outranks a timeout while in REQ.
    always_comb begin
        w_start   = 1'b0;
        w_mis_err = 1'b0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        w_req_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start   = !w_jump && !w_misaligned;
                w_mis_err = !w_jump &&  w_misaligned;
            end
            ST_REQ: begin
                w_done    = mem_ready_i && !w_jump;
                w_abort   = !mem_ready_i && !w_jump && w_terminal;
                w_req_end = mem_ready_i || w_abort;
            end
            ST_DROP: begin
                w_req_end = mem_ready_i || w_terminal;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_REQ;
            ST_REQ: begin
                if (mem_ready_i)     w_state_next = ST_IDLE;
                else if (w_jump)     w_state_next = ST_DROP;
                else if (w_terminal) w_state_next = ST_IDLE;
            end
            ST_DROP: if (w_req_end) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The PC may only advance on a cycle that produces a decode-visible result.
    always_comb begin
        hold_flag_o = HOLD_ENABLE;
        if (rst && (w_done || w_abort || w_mis_err)) begin
            hold_flag_o = HOLD_DISABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst       <= NOP_INST;
            r_inst_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
            if (w_start) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= pc_i;
            end
            if (w_req_end) begin
                r_mem_req <= 1'b0;
            end
            if (w_done) begin
                r_inst       <= mem_rdata_i;
                r_inst_addr  <= r_mem_addr;
                r_inst_valid <= 1'b1;
            end
            if (w_abort) begin
                r_inst       <= NOP_INST;
                r_inst_addr  <= r_mem_addr;
                r_inst_valid <= 1'b1;
                r_fetch_err  <= 1'b1;
            end
            if (w_mis_err) begin
                r_inst       <= NOP_INST;
                r_inst_addr  <= pc_i;
                r_inst_valid <= 1'b1;
                r_fetch_err  <= 1'b1;
            end
        end
    end

    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_inst_valid;
    assign fetch_err_o  = r_fetch_err;

endmodule
